viterbi_dispatch_scheduler: RTL and testbench
=============================================

// Module: viterbi_dispatch_scheduler
// PURPOSE
//  Read-side scheduler for the viterbi chunk FIFOs. Drains the FIFOs in strict write order (round-robin read
//  pointer) and issues each chunk to a free viterbi core, with a wrapping sequence tag for in-order reassembly.
//  Sits between the FIFO bank (filled by the write-side FIFO controller) and the pool of viterbi cores.
// PARAMETERS
//  num_of_viterbi_fifos  4  FIFOs in the bank; read pointer wraps modulo this
//  num_of_viterbi_cores  2  viterbi cores sharing the FIFO bank
//  num_of_chunks         5  chunks per frame; sets start_loc width $clog2(num_of_chunks)
//  tag_width             4  sequence tag width; tag wraps modulo 2**tag_width
// PORTS
//  clk             in   1     clock
//  rst_n           in   1     reset, asynchronous, active-low
//  en_sched        in   1     level enable; 1 = issue, 0 = drain then idle
//  fifo_empty      in   F     per-FIFO empty flag (F = num_of_viterbi_fifos)
//  fifo_start_loc  in   F x L head-entry start location per FIFO (L = $clog2(num_of_chunks))
//  core_done       in   C     per-core one-cycle completion pulse (C = num_of_viterbi_cores)
//  pop_n           out  F     active-low one-hot pop strobe, one cycle per dispatch
//  core_start      out  C     one-hot start pulse to the selected core
//  core_start_loc  out  L     start location issued with core_start
//  core_tag        out  tag_width  sequence tag issued with core_start
//  sched_idle      out  1     1 in IDLE
//  err_spurious    out  1     sticky: core_done seen for a non-busy core
// BEHAVIOUR
//  Reset values: pop_n all 1; core_start 0; core_start_loc 0; core_tag 0; sched_idle 1; err_spurious 0;
//   internal r_ptr 0, tag counter 0, busy vector 0, state IDLE.
//  FSM: IDLE -> RUN when en_sched=1. RUN -> DRAIN when en_sched=0.
//   DRAIN -> IDLE when busy==0 (after done updates); DRAIN -> RUN if en_sched returns to 1.
//   On IDLE entry, r_ptr and tag counter reset to 0.
//  Dispatch condition (cycle N): state==RUN && !fifo_empty[r_ptr] && any core with busy[c]==0.
//   Core choice: lowest-index non-busy core, using busy registered at start of cycle N.
//  Outputs are registered; latency is 1 cycle. In cycle N+1: pop_n[r_ptr]=0, core_start[c]=1,
//   core_start_loc=fifo_start_loc[r_ptr] sampled in N, core_tag=tag. All strobes last exactly one cycle.
//  At the N->N+1 edge: busy[c] set; r_ptr <= (r_ptr==F-1) ? 0 : r_ptr+1; tag <= tag+1 (natural wrap).
//  At most one dispatch per cycle. Never skip an empty FIFO: r_ptr stalls until that FIFO fills (order preserved).
//  core_done[c] clears busy[c] at the next edge. The core becomes eligible the cycle after done, not in the
//   done cycle. A simultaneous done on core j and dispatch to core k!=j are both honoured.
//  core_done on a core with busy==0: ignored for busy state, err_spurious set, cleared only by reset.
//  No dispatch in IDLE or DRAIN; chunks left in the FIFOs stay there.
//  Reset asserted mid-dispatch: all outputs return to reset values immediately (async); in-flight core state is
//   not tracked after reset.
//  core_start_loc/core_tag hold their last issued value between dispatches.
// STRUCTURE
//  Shared package viterbi_sched_pkg: sched_state_t enum {IDLE, RUN, DRAIN}; ptr wrap helper function.
//  One sub-module: viterbi_core_picker (combinational lowest-index free-core select; returns one-hot and valid).
//  FSM, r_ptr, tag counter, busy vector and output registers live in the top module.
// TESTING
//  1. F=4,C=2, all FIFOs non-empty, en_sched=1, cores done 3 cycles after start -> pop_n order 1110,1101,1011,0111
//     then wraps to 1110; tags 0,1,2,3,4; core_start alternates 01,10 as each core frees.
//  2. fifo_empty[1]=1 with r_ptr=1, others full -> no pop, no start until empty[1] falls; then pop_n=1101
//     one cycle later.
//  3. Both cores busy; core_done=01 in cycle N -> core_start=01 no earlier than cycle N+2; busy core 1 untouched.
//  4. en_sched drops with 2 cores busy -> no further pops, sched_idle=0 until the last done, then 1;
//     re-enable gives tag 0 and pop_n=1110.
//  5. core_done=10 while busy=00 -> err_spurious=1 and stays 1; reset clears it.
//  6. rst_n low in the cycle core_start=1 -> outputs go to reset values without waiting for clk; tag restarts at 0.

Source files
------------

// File: rtl/viterbi_dispatch_scheduler_pkg.sv
// Shared definitions for the viterbi dispatch scheduler.
//  - sched_state_t : scheduler FSM states
//  - DEF_*         : default sizing of the FIFO bank / core pool
//  - ptr_next()    : modulo-depth increment used for the round-robin read pointer
package viterbi_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } sched_state_t;

  localparam int DEF_NUM_FIFOS  = 4;
  localparam int DEF_NUM_CORES  = 2;
  localparam int DEF_NUM_CHUNKS = 5;
  localparam int DEF_TAG_WIDTH  = 4;

  // Next value of a pointer that wraps at depth (depth need not be a power of 2).
  function automatic int ptr_next(input int ptr, input int depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/viterbi_dispatch_scheduler_if.sv
// Bus between the dispatch scheduler, the FIFO bank and the viterbi core pool.
//  FIFO side : fifo_empty, fifo_start_loc (in to scheduler), pop_n (out, active-low one-hot)
//  Core side : core_done (in), core_start, core_start_loc, core_tag (out)
//  master = scheduler view, slave = FIFO bank / core pool view.
interface viterbi_dispatch_scheduler_if
  import viterbi_sched_pkg::*;
#(
  parameter int num_of_viterbi_fifos = DEF_NUM_FIFOS,
  parameter int num_of_viterbi_cores = DEF_NUM_CORES,
  parameter int loc_width            = $clog2(DEF_NUM_CHUNKS),
  parameter int tag_width            = DEF_TAG_WIDTH
) ();

  logic [num_of_viterbi_fifos-1:0]                fifo_empty;
  logic [num_of_viterbi_fifos-1:0][loc_width-1:0] fifo_start_loc;
  logic [num_of_viterbi_cores-1:0]                core_done;
  logic [num_of_viterbi_fifos-1:0]                pop_n;
  logic [num_of_viterbi_cores-1:0]                core_start;
  logic [loc_width-1:0]                           core_start_loc;
  logic [tag_width-1:0]                           core_tag;

  modport master (
    input  fifo_empty, fifo_start_loc, core_done,
    output pop_n, core_start, core_start_loc, core_tag
  );

  modport slave (
    output fifo_empty, fifo_start_loc, core_done,
    input  pop_n, core_start, core_start_loc, core_tag
  );

endinterface

// File: rtl/viterbi_dispatch_scheduler_picker.sv
// viterbi_core_picker: combinational lowest-index free-core select.
//  busy        in  C  per-core busy flag
//  pick_onehot out C  one-hot of the lowest-index core with busy==0 (0 if none)
//  pick_valid  out 1  1 when any core is free
module viterbi_core_picker #(
  parameter int num_of_viterbi_cores = 2
) (
  input  logic [num_of_viterbi_cores-1:0] busy,
  output logic [num_of_viterbi_cores-1:0] pick_onehot,
  output logic                            pick_valid
);

  always_comb begin
    pick_onehot = '0;
    pick_valid  = 1'b0;
    for (int i = 0; i < num_of_viterbi_cores; i++) begin
      if (!busy[i] && !pick_valid) begin
        pick_onehot[i] = 1'b1;
        pick_valid     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/viterbi_dispatch_scheduler.sv
// viterbi_dispatch_scheduler: read-side scheduler for the viterbi chunk FIFOs.
// Drains the FIFO bank in strict round-robin order and hands each chunk to the
// lowest-index free core together with a wrapping sequence tag.
//  clk, rst_n    clock, asynchronous active-low reset
//  en_sched      1 = issue chunks, 0 = let in-flight cores finish, then idle
//  bus (master)  FIFO flags/heads in, pop_n out; core_done in, core_start/loc/tag out
//  sched_idle    1 while the FSM is in IDLE
//  err_spurious  sticky flag: core_done seen for a core that was not busy
// All bus outputs are registered: a dispatch decided in cycle N appears in N+1.
module viterbi_dispatch_scheduler
  import viterbi_sched_pkg::*;
#(
  parameter int num_of_viterbi_fifos = DEF_NUM_FIFOS,
  parameter int num_of_viterbi_cores = DEF_NUM_CORES,
  parameter int num_of_chunks        = DEF_NUM_CHUNKS,
  parameter int tag_width            = DEF_TAG_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en_sched,
  viterbi_dispatch_scheduler_if.master  bus,
  output logic                          sched_idle,
  output logic                          err_spurious
);

  localparam int F  = num_of_viterbi_fifos;
  localparam int C  = num_of_viterbi_cores;
  localparam int L  = (num_of_chunks > 1) ? $clog2(num_of_chunks) : 1;
  localparam int PW = (F > 1) ? $clog2(F) : 1;
  localparam int TW = tag_width;

  sched_state_t   state_q, state_d;
  logic [PW-1:0]  r_ptr_q, r_ptr_d;
  logic [TW-1:0]  tag_q, tag_d;
  logic [C-1:0]   busy_q, busy_d;
  logic           err_q, err_d;
  logic [F-1:0]   pop_n_q, pop_n_d;
  logic [C-1:0]   core_start_q, core_start_d;
  logic [L-1:0]   start_loc_q, start_loc_d;
  logic [TW-1:0]  core_tag_q, core_tag_d;

  logic [C-1:0]   pick_onehot;
  logic           pick_valid;
  logic           dispatch;

  // Core choice uses busy as registered at the start of the cycle, so a core
  // whose done arrives this cycle is only eligible from the next one.
  viterbi_core_picker #(
    .num_of_viterbi_cores (C)
  ) u_picker (
    .busy        (busy_q),
    .pick_onehot (pick_onehot),
    .pick_valid  (pick_valid)
  );

  always_comb begin
    state_d      = state_q;
    r_ptr_d      = r_ptr_q;
    tag_d        = tag_q;
    pop_n_d      = '1;
    core_start_d = '0;
    start_loc_d  = start_loc_q;
    core_tag_d   = core_tag_q;

    // The head FIFO is never skipped: an empty head stalls the pointer.
    dispatch = (state_q == RUN) && !bus.fifo_empty[r_ptr_q] && pick_valid;

    // Done on an idle core must not disturb busy, it only raises the error.
    busy_d = busy_q & ~bus.core_done;
    err_d  = err_q | (|(bus.core_done & ~busy_q));

    if (dispatch) begin
      pop_n_d[r_ptr_q] = 1'b0;
      core_start_d     = pick_onehot;
      start_loc_d      = bus.fifo_start_loc[r_ptr_q];
      core_tag_d       = tag_q;
      busy_d           = busy_d | pick_onehot;
      r_ptr_d          = PW'(ptr_next(int'(r_ptr_q), F));
      tag_d            = tag_q + 1'b1;
    end

    unique case (state_q)
      IDLE:    if (en_sched) state_d = RUN;
      RUN:     if (!en_sched) state_d = DRAIN;
      DRAIN: begin
        if (en_sched)           state_d = RUN;
        else if (busy_d == '0)  state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Each enable episode restarts the write-order walk and the tag sequence.
    if (state_d == IDLE) begin
      r_ptr_d = '0;
      tag_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      r_ptr_q      <= '0;
      tag_q        <= '0;
      busy_q       <= '0;
      err_q        <= 1'b0;
      pop_n_q      <= '1;
      core_start_q <= '0;
      start_loc_q  <= '0;
      core_tag_q   <= '0;
    end else begin
      state_q      <= state_d;
      r_ptr_q      <= r_ptr_d;
      tag_q        <= tag_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
      pop_n_q      <= pop_n_d;
      core_start_q <= core_start_d;
      start_loc_q  <= start_loc_d;
      core_tag_q   <= core_tag_d;
    end
  end

  assign bus.pop_n          = pop_n_q;
  assign bus.core_start     = core_start_q;
  assign bus.core_start_loc = start_loc_q;
  assign bus.core_tag       = core_tag_q;
  assign sched_idle         = (state_q == IDLE);
  assign err_spurious       = err_q;

endmodule

// File: tb/tb_viterbi_dispatch_scheduler.sv
// Directed bench for viterbi_dispatch_scheduler (F=4, C=2, 5 chunks, 4-bit tag).
// FIFO k always presents head start location k+1.
module tb_viterbi_dispatch_scheduler;

  logic clk;
  logic rst_n;
  logic en_sched;
  logic sched_idle;
  logic err_spurious;

  int checks = 0;
  int errors = 0;

  viterbi_dispatch_scheduler_if #(
    .num_of_viterbi_fifos (4),
    .num_of_viterbi_cores (2),
    .loc_width            (3),
    .tag_width            (4)
  ) bus ();

  viterbi_dispatch_scheduler #(
    .num_of_viterbi_fifos (4),
    .num_of_viterbi_cores (2),
    .num_of_chunks        (5),
    .tag_width            (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en_sched     (en_sched),
    .bus          (bus),
    .sched_idle   (sched_idle),
    .err_spurious (err_spurious)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic [3:0] empty;
    logic [1:0] done;
    logic [3:0] pop_n;
    logic [1:0] start;
    logic [2:0] loc;
    logic [3:0] tag;
    logic       idle;
    logic       err;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input logic [3:0] pop_n, input logic [1:0] start,
                         input logic [2:0] loc, input logic [3:0] tag, input logic idle,
                         input logic err);
    chk({nm, ".pop_n"}, 32'(bus.pop_n), 32'(pop_n));
    chk({nm, ".core_start"}, 32'(bus.core_start), 32'(start));
    chk({nm, ".core_start_loc"}, 32'(bus.core_start_loc), 32'(loc));
    chk({nm, ".core_tag"}, 32'(bus.core_tag), 32'(tag));
    chk({nm, ".sched_idle"}, 32'(sched_idle), 32'(idle));
    chk({nm, ".err_spurious"}, 32'(err_spurious), 32'(err));
  endtask

  // Apply inputs for one cycle, then sample registered outputs 1ns after the edge.
  task automatic cyc(input logic e, input logic [3:0] emp, input logic [1:0] dn);
    en_sched       = e;
    bus.fifo_empty = emp;
    bus.core_done  = dn;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Cycle-by-cycle round-robin run: both cores, dones returned by the bench.
    tbl[0] = '{en:1'b1, empty:4'b0000, done:2'b00, pop_n:4'b1111, start:2'b00, loc:3'd0, tag:4'd0, idle:1'b0, err:1'b0};
    tbl[1] = '{en:1'b1, empty:4'b0000, done:2'b00, pop_n:4'b1110, start:2'b01, loc:3'd1, tag:4'd0, idle:1'b0, err:1'b0};
    tbl[2] = '{en:1'b1, empty:4'b0000, done:2'b00, pop_n:4'b1101, start:2'b10, loc:3'd2, tag:4'd1, idle:1'b0, err:1'b0};
    tbl[3] = '{en:1'b1, empty:4'b0000, done:2'b00, pop_n:4'b1111, start:2'b00, loc:3'd2, tag:4'd1, idle:1'b0, err:1'b0};
    tbl[4] = '{en:1'b1, empty:4'b0000, done:2'b01, pop_n:4'b1111, start:2'b00, loc:3'd2, tag:4'd1, idle:1'b0, err:1'b0};
    tbl[5] = '{en:1'b1, empty:4'b0000, done:2'b10, pop_n:4'b1011, start:2'b01, loc:3'd3, tag:4'd2, idle:1'b0, err:1'b0};
    tbl[6] = '{en:1'b1, empty:4'b0000, done:2'b00, pop_n:4'b0111, start:2'b10, loc:3'd4, tag:4'd3, idle:1'b0, err:1'b0};
    tbl[7] = '{en:1'b1, empty:4'b0000, done:2'b00, pop_n:4'b1111, start:2'b00, loc:3'd4, tag:4'd3, idle:1'b0, err:1'b0};
    tbl[8] = '{en:1'b1, empty:4'b0000, done:2'b01, pop_n:4'b1111, start:2'b00, loc:3'd4, tag:4'd3, idle:1'b0, err:1'b0};
    tbl[9] = '{en:1'b1, empty:4'b0000, done:2'b00, pop_n:4'b1110, start:2'b01, loc:3'd1, tag:4'd4, idle:1'b0, err:1'b0};

    rst_n    = 1'b0;
    en_sched = 1'b0;
    bus.fifo_empty = 4'b1111;
    bus.core_done  = 2'b00;
    for (int k = 0; k < 4; k++) bus.fifo_start_loc[k] = 3'(k + 1);

    #12;
    chk_all("reset", 4'b1111, 2'b00, 3'd0, 4'd0, 1'b1, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      cyc(tbl[i].en, tbl[i].empty, tbl[i].done);
      chk_all($sformatf("rr_row%0d", i), tbl[i].pop_n, tbl[i].start, tbl[i].loc,
              tbl[i].tag, tbl[i].idle, tbl[i].err);
    end

    // Head FIFO 1 empty: pointer stalls even though core 0 frees up.
    cyc(1'b1, 4'b0010, 2'b01);
    chk_all("stall_done", 4'b1111, 2'b00, 3'd1, 4'd4, 1'b0, 1'b0);
    cyc(1'b1, 4'b0010, 2'b00);
    chk_all("stall_a", 4'b1111, 2'b00, 3'd1, 4'd4, 1'b0, 1'b0);
    cyc(1'b1, 4'b0010, 2'b00);
    chk_all("stall_b", 4'b1111, 2'b00, 3'd1, 4'd4, 1'b0, 1'b0);
    cyc(1'b1, 4'b0000, 2'b00);
    chk_all("fifo1_fills", 4'b1101, 2'b01, 3'd2, 4'd5, 1'b0, 1'b0);
    // Core 1 was never released: nothing further can issue.
    cyc(1'b1, 4'b0000, 2'b00);
    chk_all("core1_still_busy", 4'b1111, 2'b00, 3'd2, 4'd5, 1'b0, 1'b0);

    // Disable with both cores busy: drain until the last done.
    cyc(1'b0, 4'b0000, 2'b00);
    chk_all("drain_enter", 4'b1111, 2'b00, 3'd2, 4'd5, 1'b0, 1'b0);
    cyc(1'b0, 4'b0000, 2'b01);
    chk_all("drain_done0", 4'b1111, 2'b00, 3'd2, 4'd5, 1'b0, 1'b0);
    cyc(1'b0, 4'b0000, 2'b00);
    chk_all("drain_wait", 4'b1111, 2'b00, 3'd2, 4'd5, 1'b0, 1'b0);
    cyc(1'b0, 4'b0000, 2'b10);
    chk_all("drain_to_idle", 4'b1111, 2'b00, 3'd2, 4'd5, 1'b1, 1'b0);

    // Done for a core that is not busy raises the sticky error.
    cyc(1'b0, 4'b0000, 2'b10);
    chk_all("spurious_done", 4'b1111, 2'b00, 3'd2, 4'd5, 1'b1, 1'b1);
    cyc(1'b1, 4'b0000, 2'b00);
    chk_all("reenable_run", 4'b1111, 2'b00, 3'd2, 4'd5, 1'b0, 1'b1);
    cyc(1'b1, 4'b0000, 2'b00);
    chk_all("reenable_first", 4'b1110, 2'b01, 3'd1, 4'd0, 1'b0, 1'b1);

    // Asynchronous reset while core_start is high, well before the next edge.
    #1;
    rst_n = 1'b0;
    #1;
    chk_all("async_reset", 4'b1111, 2'b00, 3'd0, 4'd0, 1'b1, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b1, 4'b0000, 2'b00);
    chk_all("post_reset_run", 4'b1111, 2'b00, 3'd0, 4'd0, 1'b0, 1'b0);
    cyc(1'b1, 4'b0000, 2'b00);
    chk_all("post_reset_first", 4'b1110, 2'b01, 3'd1, 4'd0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
